// File: rtl/vector_stream_loader.sv
// Byte-stream front-end for the adder tree: loads array_a/array_b, waits for the tree to settle,
// then streams the captured sum out little-endian. Define VSL_CHKSUM_EN to append an XOR checksum byte.
module vector_stream_loader #(
  parameter int WIDTH         = 8,
  parameter int LENGTH        = 512,
  parameter int SETTLE_CYCLES = 2,
  localparam int RW           = $clog2(LENGTH*2) + WIDTH + 1,
  localparam int NBYTES       = (RW + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  array_a [LENGTH],
  output logic [WIDTH-1:0]  array_b [LENGTH],
  input  logic [RW-1:0]     sum_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(NBYTES + 2);
`ifdef VSL_CHKSUM_EN
  localparam int LAST_B = NBYTES;
`else
  localparam int LAST_B = NBYTES - 1;
`endif

  typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, SEND} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        idx;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bidx;
  logic [RW-1:0]        res_q;
  logic [NBYTES*8-1:0]  res_pad;
  logic                 in_fire, out_fire, idx_last, settle_done;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign idx_last    = (idx == IW'(LENGTH - 1));
  assign settle_done = (scnt == SW'(SETTLE_CYCLES - 1));
  assign busy        = !(state == LOAD_A && idx == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = !rst;
        if (in_fire && idx_last) state_nx = LOAD_B;
      end
      LOAD_B: begin
        in_ready = !rst;
        if (in_fire && idx_last) state_nx = SETTLE;
      end
      SETTLE: if (settle_done) state_nx = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_fire && bidx == BW'(LAST_B)) state_nx = LOAD_A;
      end
      default: state_nx = LOAD_A;
    endcase
  end

  // Byte select via constant-index loop; bytes above RW read as zero padding.
  always_comb begin
    res_pad          = '0;
    res_pad[RW-1:0]  = res_q;
    out_data         = 8'h00;
    if (state == SEND) begin
      for (int i = 0; i < NBYTES; i++)
        if (bidx == BW'(i)) out_data = res_pad[8*i +: 8];
`ifdef VSL_CHKSUM_EN
      if (bidx == BW'(NBYTES))
        for (int i = 0; i < NBYTES; i++) out_data = out_data ^ res_pad[8*i +: 8];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      scnt  <= '0;
      bidx  <= '0;
      res_q <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        array_a[i] <= '0;
        array_b[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        idx <= idx_last ? '0 : idx + 1'b1;
        if (state == LOAD_A) array_a[idx] <= in_data[WIDTH-1:0];
        else                 array_b[idx] <= in_data[WIDTH-1:0];
      end
      if (state == LOAD_B && in_fire && idx_last) scnt <= '0;
      else if (state == SETTLE) begin
        scnt <= scnt + 1'b1;
        if (settle_done) begin
          res_q <= sum_in;
          bidx  <= '0;
        end
      end
      if (out_fire) bidx <= (bidx == BW'(LAST_B)) ? '0 : bidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_vector_stream_loader.sv
// Directed/random bench for vector_stream_loader with LENGTH=4, WIDTH=8, SETTLE_CYCLES=2.
module tb_vector_stream_loader;
  localparam int RW = 12;
`ifdef VSL_CHKSUM_EN
  localparam int NB_OUT = 3;
`else
  localparam int NB_OUT = 2;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic [7:0]  in_data = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  array_a [4];
  logic [7:0]  array_b [4];
  logic [RW-1:0] sum_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 0;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  vector_stream_loader #(.WIDTH(8), .LENGTH(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .array_a(array_a), .array_b(array_b), .sum_in(sum_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  always #5 clk = ~clk;

  // Adder tree attached to the operand arrays.
  always_comb begin
    logic [15:0] t;
    t = 0;
    for (int i = 0; i < 4; i++) t = t + 16'(array_a[i]) + 16'(array_b[i]);
    sum_in = t[RW-1:0];
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    in_data = d; in_valid = 1;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("push_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic pull(input int stall, output logic [7:0] d);
    int n = 0;
    logic [7:0] d0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) check("pull_timeout", 0, 1);
    check("send_in_ready", 32'(in_ready), 0);
    d0 = out_data;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("bp_data", 32'(out_data), 32'(d0));
      check("bp_valid", 32'(out_valid), 1);
    end
    d = out_data;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic run(input logic [7:0] v[8], input int gap_pct, input int stall, input string nm);
    logic [15:0] s;
    logic [7:0]  d, x, e;
    s = 0; x = 0;
    for (int i = 0; i < 8; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) tick();
      push(v[i]);
      s = s + 16'(v[i]);
    end
    // now in cycle T+1 after the last accept at edge T
    check({nm, "_settle1_valid"}, 32'(out_valid), 0);
    check({nm, "_settle1_ready"}, 32'(in_ready), 0);
    check({nm, "_settle_busy"}, 32'(busy), 1);
    tick();
    check({nm, "_settle2_valid"}, 32'(out_valid), 0);
    check({nm, "_settle2_ready"}, 32'(in_ready), 0);
    tick();
    check({nm, "_valid_rise"}, 32'(out_valid), 1);
    for (int i = 0; i < 4; i++) begin
      check({nm, "_arr_a"}, 32'(array_a[i]), 32'(v[i]));
      check({nm, "_arr_b"}, 32'(array_b[i]), 32'(v[4+i]));
    end
    for (int k = 0; k < NB_OUT; k++) begin
      pull(k == 0 ? stall : 0, d);
      e = (k < 2) ? s[8*k +: 8] : x;
      check({nm, "_byte"}, 32'(d), 32'(e));
      if (k < 2) x = x ^ e;
    end
    check({nm, "_turnaround_ready"}, 32'(in_ready), 1);
    check({nm, "_done_valid"}, 32'(out_valid), 0);
    check({nm, "_done_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] v[8];
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_arr", 32'(array_a[0] | array_b[3]), 0);
    rst = 0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40};
    run(v, 0, 0, "basic");

    v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run(v, 0, 5, "max");

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
      run(v, 40, $urandom_range(4), "rand");
    end

    // reset mid-load after 6 bytes
    for (int i = 0; i < 6; i++) push(8'(i + 5));
    check("midload_busy", 32'(busy), 1);
    rst = 1;
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) check("midrst_arr", 32'(array_a[i] | array_b[i]), 0);
    rst = 0;
    #1;
    check("midrst_release_ready", 32'(in_ready), 1);
    v = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    run(v, 0, 0, "ones");

    // back-to-back transactions, no idle cycles between them
    v = '{8'd7, 8'd9, 8'd11, 8'd13, 8'd100, 8'd200, 8'd50, 8'd25};
    run(v, 0, 0, "b2b1");
    for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
    run(v, 0, 2, "b2b2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_stream_loader.md
# vector_stream_loader

Front-end of the combinational coprocessor: receives a byte stream over a valid/ready handshake and fills two operand arrays, `array_a` then `array_b`. These arrays drive the adder tree. After a fixed settle delay the block captures the tree's sum, then streams the sum back out byte by byte over a second valid/ready handshake. It converts the tree's wide parallel interface into a narrow, flow-controlled, link-friendly interface for the host (UART/DMA bridge).

## Interface
- `WIDTH`, 8 — bits per array element; legal range 1..8; each element occupies one input byte, and only the low `WIDTH` bits are kept.
- `LENGTH`, 512 — elements per array; power of two, ≥ 2.
- `SETTLE_CYCLES`, 2 — cycles allowed for the combinational tree to settle before capture; ≥ 1.
- Derived: `RW = $clog2(LENGTH*2) + WIDTH + 1` (sum width); `NBYTES = ceil(RW/8)`.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_data`  in  8  — operand byte.
- `in_valid`  in  1  — `in_data` is valid.
- `in_ready`  out  1  — block accepts a byte; a transfer happens when `in_valid && in_ready`.
- `array_a`  out  `[WIDTH-1:0]` × `LENGTH` (unpacked)  — operand A registers.
- `array_b`  out  `[WIDTH-1:0]` × `LENGTH` (unpacked)  — operand B registers.
- `sum_in`  in  `RW`  — sum returned by the adder tree.
- `out_data`  out  8  — result byte.
- `out_valid`  out  1  — `out_data` is valid.
- `out_ready`  in  1  — sink accepts a byte; a transfer happens when `out_valid && out_ready`.
- `busy`  out  1  — a transaction is in progress.

## Operation
- State machine states: `LOAD_A`, `LOAD_B`, `SETTLE`, `SEND`.
- Reset state is `LOAD_A`.
- **LOAD_A:** each accepted byte is written to `array_a[idx]`, then `idx` increments. On the accept at `idx == LENGTH-1`, `idx` clears and the state moves to `LOAD_B`.
- **LOAD_B:** same as `LOAD_A`, writing `array_b`. The last accept moves the state to `SETTLE` and clears `scnt`.
- **SETTLE:** `in_ready = 0`; `scnt` counts cycles. On the `SETTLE_CYCLES`-th cycle, `sum_in` is registered into `res_q`, the byte index is cleared, and the state moves to `SEND`.
- **SEND:** `out_data = res_q[8*b +: 8]`, little-endian, zero-padded above `RW`. The byte index `b` advances on each transfer. After the transfer of byte `NBYTES-1` (or of the checksum byte, see Configuration), the state returns to `LOAD_A`.
- Array contents persist across transactions until overwritten; `array_a` is stable during `LOAD_B`, `SETTLE` and `SEND`.
- `busy = !(state == LOAD_A && idx == 0)`.
- Input bytes arriving outside the `LOAD` states are not consumed because `in_ready` is low.

## Timing
- Reset values:
  - `in_ready`, `out_valid` and `busy` are 0.
  - `out_data` is 0.
  - All `array_a`/`array_b` elements, `res_q`, `idx` and `scnt` are 0.
  - While `rst` is high, `in_ready` is forced to 0.
- `in_ready` is 1 in `LOAD_A` and `LOAD_B`, including the cycle immediately after `rst` deasserts.
- Zero-bubble intake: with `in_valid` held high, one byte is taken per cycle.
- An array element updates on the clock edge of its accept.
- The last B byte is accepted at edge T. Then:
  - `SETTLE` occupies cycles T+1 .. T+`SETTLE_CYCLES`.
  - `res_q` is captured at edge T+`SETTLE_CYCLES`.
  - `out_valid` rises in cycle T+`SETTLE_CYCLES`+1.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_valid` hold unchanged.
- Consecutive transfers with `out_ready` held high occur on back-to-back cycles.
- Turnaround: after the final output transfer at edge E, `in_ready` is 1 in cycle E+1.
- Reset at any point (mid-load, mid-settle, mid-send) returns all outputs to their reset values on the next edge. The partial transaction is discarded and no partial output completes.

## Configuration
- `VSL_CHKSUM_EN` defined: after the `NBYTES` result bytes, `SEND` emits one extra byte equal to the XOR of all `NBYTES` result bytes, under the same handshake. The transaction ends after the checksum transfer.
- `VSL_CHKSUM_EN` undefined: exactly `NBYTES` bytes are emitted and there is no checksum logic.

## Test plan
All scenarios use `LENGTH=4`, `WIDTH=8`, `SETTLE_CYCLES=2`, which gives `RW=12` and `NBYTES=2`.
- Basic: stream 1,2,3,4,10,20,30,40 with tree model attached → `sum=110`; output bytes 0x6E, 0x00; out_valid rises 3 cycles after the last accept. With `VSL_CHKSUM_EN`, a third byte 0x6E follows.
- Maximum: stream all 0xFF → `sum=2040`; output bytes 0xF8, 0x07. With checksum enabled, a third byte 0xFF follows.
- Backpressure: hold `out_ready=0` for 5 cycles during `SEND` → `out_data`/`out_valid` stable; bytes emitted in order, none lost or duplicated.
- Intake stalls: toggle `in_valid` pseudo-randomly → arrays hold exactly the accepted bytes in order; `in_ready=0` throughout `SETTLE`/`SEND`.
- Reset mid-load: after 6 of 8 bytes, pulse `rst` → all arrays 0, `busy=0`. A following full 8-byte load of all 1s yields `sum=8` (bytes 0x08, 0x00).
- Back-to-back: two transactions with no idle cycles → the second result is correct, and `in_ready` is 1 the cycle after the first transaction's final transfer.
